// File: rtl/fir_decim_reader_if.sv
// Stream bundle between the FIR output, the decimating FIFO reader and its sink.
// The slave modport is the reader's view; the master modport is the producer/sink side.
interface fir_decim_reader_if #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
);
  logic [DW-1:0]              din;
  logic                       din_valid;
  logic [DW-1:0]              dout;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       ovf;

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, count, ovf
  );

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, count, ovf
  );
endinterface

// File: rtl/fir_decim_reader.sv
// Settles, decimates and buffers the filterfir output stream into a FWFT FIFO.
// Define FIR_DECIM_AVG_EN to push boxcar averages instead of picked samples.
module fir_decim_reader #(
  parameter int DECIM  = 4,
  parameter int SETTLE = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fir_decim_reader_if.slave bus
);
  localparam int DW    = 10;
  localparam int LOG2D = $clog2(DECIM);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SCW   = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [SCW-1:0]   r_settleCnt;
  logic [LOG2D-1:0] r_phase;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic             w_settled;
  logic             w_capture;
  logic             w_lastPhase;
  logic             w_push;
  logic             w_pop;
  logic             w_write;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_result;

  assign w_settled   = (r_settleCnt == SCW'(SETTLE));
  assign w_capture   = bus.din_valid && w_settled;
  assign w_lastPhase = (r_phase == LOG2D'(DECIM - 1));
  assign w_push      = w_capture && w_lastPhase;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = bus.dout_ready && !w_empty;
  // A pop frees the head slot, so a push into a full FIFO still lands that cycle.
  assign w_write     = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settleCnt <= '0;
    end else if (bus.din_valid && !w_settled) begin
      r_settleCnt <= r_settleCnt + 1'b1;
    end
  end

  // DECIM is a power of two, so the natural wrap of r_phase is the group boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (w_capture) begin
      r_phase <= r_phase + 1'b1;
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int ACW = DW + LOG2D;

  logic [ACW-1:0] r_acc;
  logic [ACW-1:0] w_sum;

  assign w_sum    = r_acc + ACW'(bus.din);
  assign w_result = w_sum[ACW-1:LOG2D];

  // Phase 0 reloads rather than accumulates, so no sum leaks across groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= (r_phase == '0) ? ACW'(bus.din) : w_sum;
    end
  end
`else
  assign w_result = bus.din;
`endif

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero when empty so dout reads 0 out of reset.
  assign bus.dout       = w_empty ? '0 : r_mem[r_rdPtr];
  assign bus.dout_valid = !w_empty;
  assign bus.count      = r_count;
  assign bus.ovf        = r_ovf;
endmodule
